// File: rtl/led_wrap_sequencer_if.sv
// Control/status bundle between the LED show sequencer and its rotator/button side.
// The sequencer takes the slave view; whatever drives buttons and the rotator takes the master view.
interface led_wrap_sequencer_if;
    logic       start;
    logic       stop;
    logic       btn_next;
    logic       clk_div_in;
    logic [3:0] led_in;
    logic       wrap_en;
    logic       wrap_dir;
    logic [7:0] wrap_div;
    logic [2:0] mode;
    logic [7:0] lap_cnt;
    logic       busy;
    logic       done;

    modport master (
        output start, stop, btn_next, clk_div_in, led_in,
        input  wrap_en, wrap_dir, wrap_div, mode, lap_cnt, busy, done
    );

    modport slave (
        input  start, stop, btn_next, clk_div_in, led_in,
        output wrap_en, wrap_dir, wrap_div, mode, lap_cnt, busy, done
    );
endinterface

// File: rtl/led_wrap_sequencer.sv
// Mode controller for the wrap-around LED rotator: runs a fixed four-mode show,
// counting laps off the rotator's divided clock and LED position.
//
// state | meaning
// IDLE  | rotator disabled, waiting for start
// LEFT  | rotate left, slow divisor
// RIGHT | rotate right, slow divisor
// PING  | bounce between end LEDs, slow divisor; lap = return to 0001
// FAST  | rotate left, fast divisor
// DONE  | single-cycle done pulse, then back to IDLE
module led_wrap_sequencer #(
    parameter int         LAPS     = 3,
    parameter logic [7:0] DIV_SLOW = 8'd8,
    parameter logic [7:0] DIV_FAST = 8'd2
) (
    input logic                 in_clk,
    input logic                 rst,
    led_wrap_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEFT  = 3'd1,
        S_RIGHT = 3'd2,
        S_PING  = 3'd3,
        S_FAST  = 3'd4,
        S_DONE  = 3'd5,
        S_BAD6  = 3'd6,
        S_BAD7  = 3'd7
    } state_t;

    localparam logic [7:0] LAP_LAST = 8'(LAPS - 1);

    state_t     state;
    state_t     nxt;
    logic       clk_div_q;
    logic       wrap_en_r;
    logic       wrap_dir_r;
    logic [7:0] wrap_div_r;
    logic [7:0] lap_cnt_r;
    logic       busy_r;
    logic       done_r;

    logic tick;
    logic at_top;
    logic at_bot;
    logic lap_ev;
    logic ping_flip;
    logic advance;

    always_comb begin
        tick      = bus.clk_div_in & ~clk_div_q;
        at_top    = (bus.led_in == 4'b1000);
        at_bot    = (bus.led_in == 4'b0001);
        lap_ev    = 1'b0;
        ping_flip = 1'b0;
        nxt       = S_IDLE;
        case (state)
            S_LEFT: begin
                lap_ev = tick & at_top;
                nxt    = S_RIGHT;
            end
            S_RIGHT: begin
                lap_ev = tick & at_bot;
                nxt    = S_PING;
            end
            S_PING: begin
                lap_ev    = tick & at_bot & ~wrap_dir_r;
                ping_flip = tick & at_top & wrap_dir_r;
                nxt       = S_FAST;
            end
            S_FAST: begin
                lap_ev = tick & at_top;
                nxt    = S_DONE;
            end
            default: ;
        endcase
        advance = bus.btn_next | (lap_ev & (lap_cnt_r == LAP_LAST));
    end

    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            clk_div_q  <= 1'b0;
            wrap_en_r  <= 1'b0;
            wrap_dir_r <= 1'b1;
            wrap_div_r <= DIV_SLOW;
            lap_cnt_r  <= 8'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            clk_div_q <= bus.clk_div_in;
            done_r    <= 1'b0;
            case (state)
                S_IDLE: begin
                    wrap_en_r <= 1'b0;
                    lap_cnt_r <= 8'd0;
                    busy_r    <= 1'b0;
                    if (bus.start) begin
                        state      <= S_LEFT;
                        wrap_en_r  <= 1'b1;
                        wrap_dir_r <= 1'b1;
                        wrap_div_r <= DIV_SLOW;
                        busy_r     <= 1'b1;
                    end
                end
                S_LEFT, S_RIGHT, S_PING, S_FAST: begin
                    if (bus.stop) begin
                        state     <= S_IDLE;
                        wrap_en_r <= 1'b0;
                        lap_cnt_r <= 8'd0;
                        busy_r    <= 1'b0;
                    end else if (advance) begin
                        // A tick landing with btn_next is swallowed by the skip.
                        state     <= nxt;
                        lap_cnt_r <= 8'd0;
                        case (nxt)
                            S_RIGHT: begin
                                wrap_dir_r <= 1'b0;
                                wrap_div_r <= DIV_SLOW;
                            end
                            S_PING: begin
                                wrap_dir_r <= 1'b1;
                                wrap_div_r <= DIV_SLOW;
                            end
                            S_FAST: begin
                                wrap_dir_r <= 1'b1;
                                wrap_div_r <= DIV_FAST;
                            end
                            default: begin
                                wrap_en_r <= 1'b0;
                                done_r    <= 1'b1;
                            end
                        endcase
                    end else if (lap_ev) begin
                        lap_cnt_r <= lap_cnt_r + 8'd1;
                        if (state == S_PING) wrap_dir_r <= 1'b1;
                    end else if (ping_flip) begin
                        wrap_dir_r <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    wrap_en_r <= 1'b0;
                    lap_cnt_r <= 8'd0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mode     = state;
    assign bus.wrap_en  = wrap_en_r;
    assign bus.wrap_dir = wrap_dir_r;
    assign bus.wrap_div = wrap_div_r;
    assign bus.lap_cnt  = lap_cnt_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;

endmodule

// File: tb/tb_led_wrap_sequencer.sv
// Directed bench for led_wrap_sequencer: full show with a simple rotator model,
// skip/stop priority, ping-pong direction handling and asynchronous reset.
module tb_led_wrap_sequencer;

    logic in_clk;
    logic rst;
    led_wrap_sequencer_if bus();

    led_wrap_sequencer #(.LAPS(3), .DIV_SLOW(8'd8), .DIV_FAST(8'd2)) dut (
        .in_clk (in_clk),
        .rst    (rst),
        .bus    (bus.slave)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    int n_chk  = 0;
    int n_pass = 0;
    int done_cnt = 0;
    logic [3:0] rot_led;
    logic [2:0] tick_mode;

    always @(negedge in_clk) if (bus.done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge in_clk);
        #1;
    endtask

    task automatic tick(input logic [3:0] led);
        bus.led_in     = led;
        bus.clk_div_in = 1'b1;
        cyc();
        bus.clk_div_in = 1'b0;
        cyc();
    endtask

    // Rotator model: one LED shift per divided-clock period in the commanded direction.
    task automatic rot_step();
        if (bus.wrap_dir) rot_led = {rot_led[2:0], rot_led[3]};
        else              rot_led = {rot_led[0], rot_led[3:1]};
        bus.led_in     = rot_led;
        bus.clk_div_in = 1'b1;
        cyc();
        tick_mode      = bus.mode;
        bus.clk_div_in = 1'b0;
        cyc();
    endtask

    int exp_steps [4] = '{11, 11, 18, 11};
    int exp_div   [4] = '{8, 8, 8, 2};
    int steps;
    int maxlap;
    int done_base;

    initial begin
        rst = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.btn_next = 1'b0;
        bus.clk_div_in = 1'b0; bus.led_in = 4'b0001;
        rot_led = 4'b0001;
        #12;
        chk("rst_en",   bus.wrap_en,  0);
        chk("rst_dir",  bus.wrap_dir, 1);
        chk("rst_div",  bus.wrap_div, 8);
        chk("rst_mode", bus.mode,     0);
        chk("rst_lap",  bus.lap_cnt,  0);
        chk("rst_busy", bus.busy,     0);
        chk("rst_done", bus.done,     0);
        rst = 1'b1;
        cyc();

        // Full show
        bus.start = 1'b1; cyc(); bus.start = 1'b0;
        chk("start_en",   bus.wrap_en, 1);
        chk("start_busy", bus.busy,    1);
        chk("start_dir",  bus.wrap_dir, 1);
        for (int m = 0; m < 4; m++) begin
            chk("show_mode", bus.mode, m + 1);
            chk("show_div",  bus.wrap_div, exp_div[m]);
            steps = 0;
            maxlap = 0;
            while (bus.mode == 3'(m + 1) && steps < 100) begin
                rot_step();
                steps++;
                if (int'(bus.lap_cnt) > maxlap) maxlap = int'(bus.lap_cnt);
            end
            chk("show_steps",  steps,  exp_steps[m]);
            chk("show_maxlap", maxlap, 2);
        end
        chk("show_done_mode", tick_mode, 5);
        chk("show_done_cnt",  done_cnt,  1);
        chk("show_end_mode",  bus.mode,  0);
        chk("show_end_busy",  bus.busy,  0);
        chk("show_end_en",    bus.wrap_en, 0);
        chk("show_idle_div",  bus.wrap_div, 2);

        // btn_next in LEFT after one lap; start ignored while busy
        bus.start = 1'b1; cyc(); bus.start = 1'b0;
        tick(4'b1000);
        chk("left_lap1", bus.lap_cnt, 1);
        bus.start = 1'b1; cyc(); bus.start = 1'b0;
        chk("start_ignored", bus.mode, 1);
        bus.btn_next = 1'b1; cyc(); bus.btn_next = 1'b0;
        chk("next_mode", bus.mode, 2);
        chk("next_lap",  bus.lap_cnt, 0);
        chk("next_dir",  bus.wrap_dir, 0);

        // PING direction handling
        bus.btn_next = 1'b1; cyc(); bus.btn_next = 1'b0;
        chk("ping_mode", bus.mode, 3);
        chk("ping_dir0", bus.wrap_dir, 1);
        tick(4'b1000);
        chk("ping_flip_dir", bus.wrap_dir, 0);
        chk("ping_flip_lap", bus.lap_cnt, 0);
        tick(4'b0001);
        chk("ping_ret_dir", bus.wrap_dir, 1);
        chk("ping_ret_lap", bus.lap_cnt, 1);
        tick(4'b1001);
        chk("ping_nonhot_lap",  bus.lap_cnt, 1);
        chk("ping_nonhot_mode", bus.mode, 3);

        // Tick coinciding with btn_next in FAST
        bus.btn_next = 1'b1; cyc(); bus.btn_next = 1'b0;
        chk("fast_mode", bus.mode, 4);
        chk("fast_div",  bus.wrap_div, 2);
        tick(4'b1000);
        chk("fast_lap1", bus.lap_cnt, 1);
        done_base = done_cnt;
        bus.led_in = 4'b1000; bus.clk_div_in = 1'b1; bus.btn_next = 1'b1;
        cyc();
        bus.clk_div_in = 1'b0; bus.btn_next = 1'b0;
        chk("fastnext_mode", bus.mode, 5);
        chk("fastnext_done", bus.done, 1);
        chk("fastnext_lap",  bus.lap_cnt, 0);
        cyc();
        chk("fastnext_idle", bus.mode, 0);
        chk("fastnext_done_cnt", done_cnt - done_base, 1);

        // stop and btn_next together in RIGHT
        bus.start = 1'b1; cyc(); bus.start = 1'b0;
        bus.btn_next = 1'b1; cyc(); bus.btn_next = 1'b0;
        chk("right_mode", bus.mode, 2);
        done_base = done_cnt;
        bus.stop = 1'b1; bus.btn_next = 1'b1; cyc();
        bus.stop = 1'b0; bus.btn_next = 1'b0;
        chk("stop_mode", bus.mode, 0);
        chk("stop_en",   bus.wrap_en, 0);
        chk("stop_busy", bus.busy, 0);
        chk("stop_lap",  bus.lap_cnt, 0);
        cyc();
        chk("stop_no_done", done_cnt - done_base, 0);

        // Asynchronous reset mid-FAST
        bus.start = 1'b1; cyc(); bus.start = 1'b0;
        tick(4'b1000);
        repeat (3) begin bus.btn_next = 1'b1; cyc(); bus.btn_next = 1'b0; end
        chk("pre_rst_mode", bus.mode, 4);
        done_base = done_cnt;
        #2 rst = 1'b0;
        #1;
        chk("arst_mode", bus.mode, 0);
        chk("arst_en",   bus.wrap_en, 0);
        chk("arst_dir",  bus.wrap_dir, 1);
        chk("arst_div",  bus.wrap_div, 8);
        chk("arst_busy", bus.busy, 0);
        chk("arst_lap",  bus.lap_cnt, 0);
        cyc();
        rst = 1'b1;
        cyc();
        chk("arst_no_done", done_cnt - done_base, 0);
        bus.start = 1'b1; cyc(); bus.start = 1'b0;
        chk("restart_mode", bus.mode, 1);
        chk("restart_div",  bus.wrap_div, 8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
